dmem_resp: RTL
==============

# dmem_resp

Multi-cycle data-memory responder for the pipelined MIPS core. It is the memory-stage counterpart of the datapath's load/store interface: it accepts the address, write data and read/write strobes, performs word accesses on an internal array after a fixed latency, and returns read data. While an access is in flight it asserts a stall back to the hazard logic.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words; power of two, ≥ 2.
- `AW`, 6: word-index width; must equal log2(`DEPTH`).
- `LATENCY`, 2: cycles `stallM` is high per access; ≥ 1.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memreadM`  in  1  load request.
- `memwriteM`  in  1  store request.
- `addrM`  in  32  byte address (core's ALU result in M).
- `writedataM`  in  32  store data.
- `readdataM`  out  32  load data, registered.
- `stallM`  out  1  access pending; core freezes all stages while high.
- `misalignM`  out  1  request with `addrM[1:0] != 0` this cycle; request is dropped.

## Operation
- Request: `memreadM | memwriteM`. If both are high, the request is treated as a write and `readdataM` holds.
- Word index is `addrM[AW+1:2]`. Bits above are ignored, so addresses alias modulo `DEPTH*4`.
- Misaligned request:
  - `misalignM = 1` combinationally.
  - `stallM = 0`.
  - No array access; FSM stays in IDLE.
- FSM has three states: IDLE, WAIT and DONE.
  - IDLE, aligned request: `stallM = 1` combinationally. Counter loads `LATENCY-1`. Go to WAIT, or to DONE if `LATENCY == 1`.
  - WAIT: `stallM = 1`. Counter decrements. At counter == 1, go to DONE.
  - Edge into DONE: array write (store) or array read into `readdataM` (load) happens exactly once.
  - DONE: `stallM = 0`, so the core advances. Unconditionally go to IDLE; the still-asserted request is not re-accepted.
- The core holds `addrM`, `writedataM` and the strobes stable while `stallM` is high. Changes during WAIT are ignored; the request latched at acceptance is used.
- `readdataM` changes only on load completion.
- Array contents are not reset.

## Timing
- Aligned access accepted in cycle 0. `stallM` is high for cycles 0 to `LATENCY-1` and low in cycle `LATENCY` (DONE). Data is valid in DONE.
- Back-to-back requests: the cycle after DONE is IDLE and accepts the next request, so stall pattern per access is `LATENCY` high, then 1 low.
- Reset values: FSM = IDLE, counter = 0, `readdataM = 0`, `stallM = 0`, `misalignM = 0`.
- Reset asserted mid-access (WAIT): the access is abandoned. An uncommitted store is not written.

## Configuration
- `DMEM_WBUF_EN` defined: adds a one-entry posted-write buffer.
  - Aligned store in IDLE with buffer empty: `stallM = 0`; index and data are captured at the edge.
  - The buffer drains into the array `LATENCY` cycles after capture, independently of the FSM.
  - Store while the buffer is full: `stallM = 1` until drain, then captured as above.
  - Load while the buffer is full: stays in IDLE with `stallM = 1` until drained, then proceeds as a normal load.
  - Reset empties the buffer without writing it.
- `DMEM_WBUF_EN` undefined: no buffer; all accesses follow the FSM above.

## Test plan
All scenarios use `DEPTH = 64`, `LATENCY = 2`.
- Reset: hold `reset = 0` → `readdataM = 0`, `stallM = 0`, `misalignM = 0`, FSM in IDLE.
- Store `0xDEADBEEF` to `0x10`, then load `0x10` → `stallM` is 1,1,0 per access; `readdataM = 0xDEADBEEF` in the load's DONE cycle.
- Load from `0x13` → `misalignM = 1`, `stallM = 0`, `readdataM` unchanged, no state change.
- Store `0x1` to `0x0`, load `0x0` next cycle → stall pattern 1,1,0,1,1,0; load returns `0x1`. Then store `0x2` to `0x100`, load `0x0` → returns `0x2` (alias).
- Store `0x55` to `0x20`; assert reset in the WAIT cycle; release; load `0x20` → returns the pre-store value, not `0x55`.
- `DMEM_WBUF_EN`: store `0xA` to `0x4` → `stallM` stays 0. Load `0x4` next cycle → `stallM` high until drain plus `LATENCY`; returns `0xA`.

Source files
------------

// File: rtl/dmem_resp.sv
// dmem_resp: multi-cycle data-memory responder with a load/store stall handshake.
// Optional DMEM_WBUF_EN adds a one-entry posted-write buffer that drains LATENCY cycles after capture.
module dmem_resp #(
  parameter int DEPTH   = 64,
  parameter int AW      = 6,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [31:0] addrM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        misalignM
);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d, idx;
  logic [31:0]     wdata_q, wdata_d, rdata_q, rdata_d;
  logic            wr_q, wr_d;
  logic [31:0]     mem [DEPTH];
  logic            req, mis, acc, blocked, to_done, mem_we;
  logic [AW-1:0]   mem_widx;
  logic [31:0]     mem_wdat;
  logic            unused_addr;

  assign req         = memreadM | memwriteM;
  assign mis         = req & (|addrM[1:0]);
  assign idx         = addrM[AW+1:2];
  assign unused_addr = ^addrM[31:AW+2];
  assign to_done     = (state_d == DONE) && (state_q != DONE);

`ifdef DMEM_WBUF_EN
  logic            buf_v_q, drain, wcap;
  logic [AW-1:0]   buf_idx_q;
  logic [31:0]     buf_dat_q;
  logic [CW-1:0]   buf_cnt_q;
  assign drain    = buf_v_q && (buf_cnt_q == '0);
  assign wcap     = (state_q == IDLE) && req && !mis && memwriteM && !buf_v_q;
  assign acc      = (state_q == IDLE) && req && !mis && !memwriteM && !buf_v_q;
  assign blocked  = (state_q == IDLE) && req && !mis && buf_v_q;
  assign mem_we   = drain;
  assign mem_widx = buf_idx_q;
  assign mem_wdat = buf_dat_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_v_q   <= 1'b0;
      buf_cnt_q <= '0;
      buf_idx_q <= '0;
      buf_dat_q <= '0;
    end else if (wcap) begin
      buf_v_q   <= 1'b1;
      buf_cnt_q <= CW'(LATENCY - 1);
      buf_idx_q <= idx;
      buf_dat_q <= writedataM;
    end else if (drain) begin
      buf_v_q   <= 1'b0;
    end else if (buf_v_q) begin
      buf_cnt_q <= buf_cnt_q - CW'(1);
    end
  end
`else
  assign acc      = (state_q == IDLE) && req && !mis;
  assign blocked  = 1'b0;
  assign mem_we   = to_done && wr_d;
  assign mem_widx = idx_d;
  assign mem_wdat = wdata_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  // Array contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdat;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: if (acc) begin
        idx_d   = idx;
        wdata_d = writedataM;
        wr_d    = memwriteM;
        cnt_d   = CW'(LATENCY - 1);
        state_d = (LATENCY == 1) ? DONE : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? DONE : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d   = (to_done && !wr_d) ? mem[idx_d] : rdata_q;
    readdataM = rdata_q;
    stallM    = reset && (((state_q == IDLE) && (acc || blocked)) || (state_q == WAIT));
    misalignM = reset && mis;
  end
endmodule
